// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the decryption datapath.
//   AES_POLY_RED : low byte of the GF(2^8) reduction polynomial 0x11B
//   aes_word_t   : one 32-bit column viewed as four bytes (row i = [i])
//   aes_state_t  : one 128-bit state viewed as four columns (column j = [j])
//   imc_state_e  : FSM encoding of the iterative InvMixColumns engine
//   xtime()      : multiply by x in GF(2^8), reduced back to 8 bits
package aes_pkg;

  localparam logic [7:0] AES_POLY_RED = 8'h1B;

  typedef logic [3:0][7:0]  aes_word_t;
  typedef logic [3:0][31:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } imc_state_e;

  // Multiply by 2 in GF(2^8); the bit shifted out of the top folds back as 0x1B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] r;
    r = {b[6:0], 1'b0};
    if (b[7]) begin
      r = r ^ AES_POLY_RED;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_mix_word.sv
// inv_mix_word: combinational InvMixColumns of one AES column.
//   in_word  [31:0] : column bytes a0..a3, a_i = in_word[8i+7:8i]
//   out_word [31:0] : transformed column, same byte layout
// The constants 9, 11, 13, 14 are assembled from the reduced chain x2, x4, x8,
// so every partial product stays 8 bits wide.
module inv_mix_word
  import aes_pkg::*;
(
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);

  aes_word_t a_s;
  aes_word_t x2_s, x4_s, x8_s;
  aes_word_t m9_s, m11_s, m13_s, m14_s;
  aes_word_t o_s;

  assign a_s = in_word;

  // Per-byte xtime chain and the four constant multiples built from it.
  always_comb begin
    x2_s  = '0;
    x4_s  = '0;
    x8_s  = '0;
    m9_s  = '0;
    m11_s = '0;
    m13_s = '0;
    m14_s = '0;
    for (int i = 0; i < 4; i++) begin
      x2_s[i]  = xtime(a_s[i]);
      x4_s[i]  = xtime(x2_s[i]);
      x8_s[i]  = xtime(x4_s[i]);
      m9_s[i]  = x8_s[i] ^ a_s[i];
      m11_s[i] = x8_s[i] ^ x2_s[i] ^ a_s[i];
      m13_s[i] = x8_s[i] ^ x4_s[i] ^ a_s[i];
      m14_s[i] = x8_s[i] ^ x4_s[i] ^ x2_s[i];
    end
  end

  // Circulant matrix {14, 11, 13, 9} applied to the column.
  always_comb begin
    o_s    = '0;
    o_s[0] = m14_s[0] ^ m11_s[1] ^ m13_s[2] ^ m9_s[3];
    o_s[1] = m9_s[0]  ^ m14_s[1] ^ m11_s[2] ^ m13_s[3];
    o_s[2] = m13_s[0] ^ m9_s[1]  ^ m14_s[2] ^ m11_s[3];
    o_s[3] = m11_s[0] ^ m13_s[1] ^ m9_s[2]  ^ m14_s[3];
  end

  assign out_word = o_s;

endmodule

// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: iterative AES-128 InvMixColumns engine.
//   clk, rst      : clock and synchronous active-high reset
//   in_valid/in_ready/in_data    : 128-bit state input handshake
//   out_valid/out_ready/out_data : 128-bit result output handshake
//   busy          : high while columns are being transformed
// A state is captured in IDLE, rewritten in place WORDS_PER_CYCLE columns per
// clock in BUSY, and held in DONE until the consumer takes it. out_data comes
// straight from the state register; nothing from in_data reaches an output
// without passing through a flop.
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int WORDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(WORDS_PER_CYCLE == 1 || WORDS_PER_CYCLE == 2 || WORDS_PER_CYCLE == 4)) begin : g_bad_wpc
    $error("inv_mix_columns_iter: WORDS_PER_CYCLE must be 1, 2 or 4");
  end

  // Counter advance per BUSY cycle; for 4 columns this wraps to 0 on its own.
  localparam logic [1:0] CNT_STEP = 2'(WORDS_PER_CYCLE);
  // Counter value of the group that ends at column 3.
  localparam logic [1:0] CNT_LAST = 2'(4 - WORDS_PER_CYCLE);

  imc_state_e fsm_q, fsm_d;
  logic [1:0] cnt_q, cnt_d;
  aes_state_t state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;

  logic [1:0]  col_idx [WORDS_PER_CYCLE];
  logic [31:0] mix_out [WORDS_PER_CYCLE];

  for (genvar k = 0; k < WORDS_PER_CYCLE; k++) begin : g_col
    assign col_idx[k] = cnt_q + 2'(k);
    inv_mix_word u_word (
      .in_word  (state_q[col_idx[k]]),
      .out_word (mix_out[k])
    );
  end

  // Next-state, counter, state-register and output-flag computation.
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = in_data;
          cnt_d   = 2'd0;
          fsm_d   = ST_BUSY;
        end else begin
          fsm_d   = ST_IDLE;
        end
      end
      ST_BUSY: begin
        for (int k = 0; k < WORDS_PER_CYCLE; k++) begin
          state_d[col_idx[k]] = mix_out[k];
        end
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == CNT_LAST) begin
          fsm_d = ST_DONE;
        end else begin
          fsm_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) begin
          fsm_d = ST_IDLE;
        end else begin
          fsm_d = ST_DONE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
        cnt_d = 2'd0;
      end
    endcase
    // Flags are registered from the next state so they line up with fsm_q.
    in_ready_d  = (fsm_d == ST_IDLE);
    out_valid_d = (fsm_d == ST_DONE);
    busy_d      = (fsm_d == ST_BUSY);
  end

  // State, counter, data register and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      cnt_q       <= 2'd0;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = state_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb_inv_mix_columns_iter: directed and round-trip bench for inv_mix_columns_iter.
module tb_inv_mix_columns_iter;

  parameter int WPC = 1;
  localparam int EXP_LAT = 4 / WPC;
  localparam int N_RT = 1000;

  localparam logic [127:0] V1_IN  = {32'hd6d7d5d5, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};
  localparam logic [127:0] V1_OUT = {32'hd5d4d4d4, 32'h01010101, 32'h5c220af2, 32'h455313db};
  localparam logic [127:0] V2_IN  = {32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6, 32'hf8bd7e4d};
  localparam logic [127:0] V2_OUT = {32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6, 32'h4c31262d};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  inv_mix_columns_iter #(.WORDS_PER_CYCLE(WPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Generic shift-and-add GF(2^8) multiply for the forward reference model.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic       hi;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
    end
    return p;
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] o0, o1, o2, o3;
    a0 = w[7:0]; a1 = w[15:8]; a2 = w[23:16]; a3 = w[31:24];
    o0 = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
    o1 = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
    o2 = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
    o3 = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
    return {o3, o2, o1, o0};
  endfunction

  function automatic logic [127:0] fwd_state(input logic [127:0] s);
    return {fwd_col(s[127:96]), fwd_col(s[95:64]), fwd_col(s[63:32]), fwd_col(s[31:0])};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called #1 after an edge: hand over one state, then wait (bounded) for out_valid.
  task automatic send_and_wait(input logic [127:0] data, output logic [127:0] res, output int lat);
    in_valid = 1'b1;
    in_data  = data;
    chk1("ready_before_accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    chk1("busy_after_accept", busy, 1'b1);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_data;
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] held;
    logic [127:0] next_orig;
    logic [127:0] exp_rt;
    logic [127:0] q[$];
    int lat, sent, recvd, cyc;
    logic acc, dlv;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk128("rst_out_data", out_data, 128'd0);

    // Directed vector with immediate consumer.
    out_ready = 1'b1;
    send_and_wait(V1_IN, res, lat);
    chk128("v1_data", res, V1_OUT);
    chkn("v1_latency", lat, EXP_LAT);
    @(posedge clk); #1;
    chk1("v1_back_idle_valid", out_valid, 1'b0);
    chk1("v1_back_idle_ready", in_ready, 1'b1);

    // Backpressure in DONE with an ignored in_valid pulse.
    out_ready = 1'b0;
    send_and_wait(V1_IN, held, lat);
    chk128("bp_first", held, V1_OUT);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        in_data  = V2_IN;
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
      @(posedge clk); #1;
      chk1("bp_valid", out_valid, 1'b1);
      chk128("bp_data", out_data, V1_OUT);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk1("bp_release_valid", out_valid, 1'b0);
    chk1("bp_release_ready", in_ready, 1'b1);
    chk1("bp_release_busy", busy, 1'b0);

    // Single column differs; the three constant columns are fixed points.
    send_and_wait(V2_IN, res, lat);
    chk128("v2_data", res, V2_OUT);
    chkn("v2_latency", lat, EXP_LAT);
    @(posedge clk); #1;

    // Reset after two processing edges, then a clean run.
    in_valid = 1'b1;
    in_data  = V2_IN;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    chk128("midrst_state", out_data, 128'd0);
    send_and_wait(V1_IN, res, lat);
    chk128("midrst_fresh", res, V1_OUT);
    chkn("midrst_latency", lat, EXP_LAT);
    @(posedge clk); #1;

    // Round trip: forward model output fed in, original expected back.
    sent = 0; recvd = 0; cyc = 0;
    next_orig = rand128();
    while (recvd < N_RT && cyc < 30000) begin
      in_valid  = (sent < N_RT);
      in_data   = fwd_state(next_orig);
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (dlv) begin
        exp_rt = (q.size() > 0) ? q[0] : 'x;
        chk128("roundtrip", out_data, exp_rt);
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        q.push_back(next_orig);
        sent++;
        next_orig = rand128();
      end
      if (dlv) begin
        if (q.size() > 0) void'(q.pop_front());
        recvd++;
      end
    end
    in_valid = 1'b0;
    chkn("rt_inputs", sent, N_RT);
    chkn("rt_outputs", recvd, sent);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns_iter.md
Name: inv_mix_columns_iter

Overview:
- Iterative AES-128 InvMixColumns engine for the decryption datapath.
- Accepts a full 128-bit state over a valid/ready handshake and transforms it column-by-column, one or more 32-bit words per cycle.
- Returns the result over a second valid/ready handshake.
- Inverse counterpart of the forward per-word MixColumns used in the encryption round. Sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse round.

Parameters:
WORDS_PER_CYCLE, 1, columns processed per clock; legal values 1, 2, 4; any other value is a compile-time error (elaboration assertion)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_data holds a state to transform
in_ready  output  1  block can accept a state this cycle
in_data  input  128  input state; column j = bits [32j+31:32j], row i of column = bits [8i+7:8i] within the column
out_valid  output  1  out_data holds a finished result
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  128  transformed state, same byte/column layout as in_data
busy  output  1  high while columns are being processed (BUSY state)

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: on a rising edge with rst=1, state=IDLE, column counter=0, state register=128'h0, out_valid=0, busy=0, in_ready=1 (from the first cycle after reset).
- rst overrides every other input. Reset mid-operation (BUSY or DONE) discards the partial or finished result with no output handshake.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready=1, out_valid=0, busy=0. When in_valid&&in_ready, load in_data into the state register, set counter=0, go to BUSY.
  - BUSY: in_ready=0, out_valid=0, busy=1. Each cycle, replace columns [counter .. counter+WORDS_PER_CYCLE-1] with their inverse mix, then counter += WORDS_PER_CYCLE. When the last group (column 3) is written, go to DONE and clear the counter (2-bit wrap to 0).
  - DONE: out_valid=1, out_data=state register, in_ready=0. When out_valid&&out_ready, go to IDLE. While out_ready=0, hold out_data stable with out_valid=1 (no drop, no change).
- Latency: out_valid rises 4/WORDS_PER_CYCLE cycles after the accept edge (4, 2, 1).
- Throughput: the next accept is no earlier than the cycle after the output handshake. No overlap of accept and deliver. in_valid while not in IDLE is ignored; the input is not sampled.
- Per-column math, over GF(2^8) with polynomial x^8+x^4+x^3+x+1 (0x11B), input bytes a0..a3:
  - o0 = 14·a0 ^ 11·a1 ^ 13·a2 ^ 9·a3
  - o1 = 9·a0 ^ 14·a1 ^ 11·a2 ^ 13·a3
  - o2 = 13·a0 ^ 9·a1 ^ 14·a2 ^ 11·a3
  - o3 = 11·a0 ^ 13·a1 ^ 9·a2 ^ 14·a3
- Multiplies are built from a reduced xtime chain (x2, x4, x8, each reduced to 8 bits with conditional ^0x1B). All intermediate values are 8 bits; no widened products leak into the XOR.
- out_data is registered and driven only from the state register. The combinational path from in_data to outputs is forbidden.

Decomposition:
- Shared package aes_pkg:
  - AES_POLY_RED = 8'h1B
  - typedef aes_word_t = logic [3:0][7:0]
  - typedef aes_state_t = logic [3:0][31:0]
  - xtime function (8-bit in, 8-bit reduced out)
- Sub-module inv_mix_word: purely combinational, 32-bit in/out, one column. Instantiated WORDS_PER_CYCLE times.
- Top module holds the FSM, counter and state register.

Test Plan:
- Reset then single state {w3,w2,w1,w0} = {32'hd6d7d5d5, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e}, out_ready=1 -> out_data = {32'hd5d4d4d4, 32'h01010101, 32'h5c220af2, 32'h455313db}; out_valid exactly 4 cycles after accept for WORDS_PER_CYCLE=1, 2 for 2, 1 for 4.
- Column-0 word 32'hf8bd7e4d, other columns 32'hc6c6c6c6, WORDS_PER_CYCLE=1 -> column 0 = 32'h4c31262d, others unchanged 32'hc6c6c6c6.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_data constant, in_ready=0; a pulse on in_valid with different data is ignored. Release -> one handshake, then IDLE.
- Reset mid-BUSY (after 2 columns) -> next cycle out_valid=0, in_ready=1, busy=0; a following fresh state yields the correct full result with no residue.
- Round-trip random: forward MixColumns model on 1000 random states, feed results back-to-back with random out_ready -> every output equals the original state; count of outputs equals count of inputs.
